// File: rtl/alu_muldiv_seq_pkg.sv
// Shared opcode and state encodings for the EXECUTE-stage ALU and its decoder.
package alu_muldiv_seq_pkg;

    typedef enum logic [3:0] {
        ALU_OP_AND   = 4'b0000,
        ALU_OP_OR    = 4'b0001,
        ALU_OP_ADD   = 4'b0010,
        ALU_OP_SLTU  = 4'b0101,
        ALU_OP_SUB   = 4'b0110,
        ALU_OP_SLT   = 4'b0111,
        ALU_OP_MULT  = 4'b1000,
        ALU_OP_MULTU = 4'b1001,
        ALU_OP_DIV   = 4'b1010,
        ALU_OP_DIVU  = 4'b1011,
        ALU_OP_MFHI  = 4'b1100,
        ALU_OP_MFLO  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Issue/result bundle between the pipeline control and the EXECUTE-stage ALU.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             div_zero;

    modport master (
        output start, control, A, B,
        input  busy, done, result, zero, overflow, div_zero
    );

    modport slave (
        input  start, control, A, B,
        output busy, done, result, zero, overflow, div_zero
    );
endinterface

// File: rtl/alu_muldiv_seq_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on operand magnitudes.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic             is_div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] p, p_nxt, prod;
    logic [WIDTH-1:0]   mb, ma_in, mb_in, qv, rv;
    logic [WIDTH:0]     sum, shl, diff;
    logic [CNT_W-1:0]   cnt;
    logic               run, div_q, neg_q, rneg_q;

    // fin flags the cycle whose closing edge performs the final iteration
    always_comb begin
        fin   = run && (cnt == LAST);
        ma_in = (sgn && A[WIDTH-1]) ? -A : A;
        mb_in = (sgn && B[WIDTH-1]) ? -B : B;
        sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mb} : '0);
        shl   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff  = shl - {1'b0, mb};
        if (div_q) begin
            if (diff[WIDTH]) p_nxt = {shl[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
            else             p_nxt = {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        end else begin
            p_nxt = {sum, p[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p      <= '0;
            mb     <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (go) begin
            p      <= {{WIDTH{1'b0}}, ma_in};
            mb     <= mb_in;
            cnt    <= '0;
            run    <= 1'b1;
            div_q  <= is_div;
            neg_q  <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_q <= sgn && A[WIDTH-1];
        end else if (run) begin
            p   <= p_nxt;
            cnt <= cnt + 1'b1;
            if (fin) run <= 1'b0;
        end
    end

    // Sign restoration: product/quotient by sign(A)^sign(B), remainder follows A
    always_comb begin
        prod = neg_q ? -p : p;
        qv   = p[WIDTH-1:0];
        rv   = p[2*WIDTH-1:WIDTH];
        if (div_q) begin
            lo = neg_q  ? -qv : qv;
            hi = rneg_q ? -rv : rv;
        end else begin
            lo = prod[WIDTH-1:0];
            hi = prod[2*WIDTH-1:WIDTH];
        end
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Registered EXECUTE-stage ALU: single-cycle ops, flags, HI/LO and iterative MULT/DIV control.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_muldiv_seq_if.slave bus
);
    alu_state_e       state_q, state_d;
    logic             busy, accept, go, is_mul_in, is_div_in, sgn_in;
    logic             pend_q, done_q, zero_q, ovf_q, dz_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, res_q;
    logic             it_fin;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH-1:0] sum, dif, res_c, hi_c, lo_c;
    logic             ovf_c, dz_c, wr_c;

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk(clk), .reset_n(reset_n), .go(go), .is_div(is_div_in), .sgn(sgn_in),
        .A(bus.A), .B(bus.B), .fin(it_fin), .hi(it_hi), .lo(it_lo)
    );

    // FIN is not busy, so a new start may be accepted while the iterative result commits
    always_comb begin
        busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
        accept    = bus.start && !busy;
        is_mul_in = (bus.control == ALU_OP_MULT) || (bus.control == ALU_OP_MULTU);
        is_div_in = (bus.control == ALU_OP_DIV)  || (bus.control == ALU_OP_DIVU);
        sgn_in    = (bus.control == ALU_OP_MULT) || (bus.control == ALU_OP_DIV);
        go        = accept && (is_mul_in || (is_div_in && (bus.B != '0)));
        state_d   = state_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (go) state_d = is_mul_in ? ST_MUL : ST_DIV;
                else    state_d = ST_IDLE;
            end
            ST_MUL, ST_DIV: if (it_fin) state_d = ST_FIN;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sum   = a_q + b_q;
        dif   = a_q - b_q;
        res_c = '0;
        ovf_c = 1'b0;
        dz_c  = 1'b0;
        wr_c  = 1'b0;
        hi_c  = hi_q;
        lo_c  = lo_q;
        case (op_q)
            ALU_OP_AND:  res_c = a_q & b_q;
            ALU_OP_OR:   res_c = a_q | b_q;
            ALU_OP_ADD: begin
                res_c = sum;
                ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                res_c = dif;
                ovf_c = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALU_OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, a_q < b_q};
            ALU_OP_MFHI: res_c = hi_q;
            ALU_OP_MFLO: res_c = lo_q;
            // Only a zero-divisor divide reaches the single-cycle commit path
            ALU_OP_DIV, ALU_OP_DIVU: begin
                res_c = '1;
                dz_c  = 1'b1;
                wr_c  = 1'b1;
                lo_c  = '1;
                hi_c  = a_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= accept && !go;
            if (accept) begin
                op_q <= bus.control;
                a_q  <= bus.A;
                b_q  <= bus.B;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= pend_q || (state_q == ST_FIN);
            if (state_q == ST_FIN) begin
                res_q  <= it_lo;
                zero_q <= (it_lo == '0);
                ovf_q  <= 1'b0;
                dz_q   <= 1'b0;
                hi_q   <= it_hi;
                lo_q   <= it_lo;
            end else if (pend_q) begin
                res_q  <= res_c;
                zero_q <= (res_c == '0);
                ovf_q  <= ovf_c;
                dz_q   <= dz_c;
                if (wr_c) begin
                    hi_q <= hi_c;
                    lo_q <= lo_c;
                end
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.result   = res_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq with hand-computed expectations.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat, busyn;

    alu_muldiv_seq_if #(.WIDTH(32)) bus();

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_ovf, input logic exp_dz);
        bus.start = 1'b1; bus.control = op; bus.A = a; bus.B = b;
        cyc();
        bus.start = 1'b0;
        chk({tag, "_early"}, 32'(bus.done), 32'd0);
        cyc();
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_zero"}, 32'(bus.zero), 32'(exp_res == 32'd0));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        chk({tag, "_dz"}, 32'(bus.div_zero), 32'(exp_dz));
    endtask

    // Bounded wait for an iterative op; optional ADD poke while busy and MFHI issued in FIN
    task automatic muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inj, input bit mf, output int l, output int bn);
        bit mfset = 1'b0;
        l = 0; bn = 0;
        bus.start = 1'b1; bus.control = op; bus.A = a; bus.B = b;
        cyc();
        bus.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) bn++;
            if (inj && i == 5) begin
                bus.start = 1'b1; bus.control = ALU_OP_ADD; bus.A = 32'd2; bus.B = 32'd3;
            end
            if (inj && i == 6) bus.start = 1'b0;
            if (mf && i > 1 && !bus.busy && !mfset) begin
                bus.start = 1'b1; bus.control = ALU_OP_MFHI; bus.A = '0; bus.B = '0;
                mfset = 1'b1;
            end
            cyc();
            if (bus.done) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0; bus.control = '0; bus.A = '0; bus.B = '0;
        #22;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_dz", 32'(bus.div_zero), 32'd0);
        reset_n = 1'b1;
        cyc();

        single("add_ovf", ALU_OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0);
        single("sub_ovf", ALU_OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        single("and", ALU_OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        single("or", ALU_OP_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0);
        single("unknown", 4'b0011, 32'h1234_5678, 32'h1, 32'h0, 1'b0, 1'b0);

        // SUB, SLT, SLTU issued on consecutive cycles
        bus.start = 1'b1; bus.control = ALU_OP_SUB; bus.A = 32'd5; bus.B = 32'd5;
        cyc();
        bus.control = ALU_OP_SLT; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1;
        cyc();
        chk("b2b_sub_done", 32'(bus.done), 32'd1);
        chk("b2b_sub_res", bus.result, 32'd0);
        chk("b2b_sub_zero", 32'(bus.zero), 32'd1);
        chk("b2b_sub_ovf", 32'(bus.overflow), 32'd0);
        bus.control = ALU_OP_SLTU; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1;
        cyc();
        bus.start = 1'b0;
        chk("b2b_slt_done", 32'(bus.done), 32'd1);
        chk("b2b_slt_res", bus.result, 32'd1);
        chk("b2b_slt_zero", 32'(bus.zero), 32'd0);
        cyc();
        chk("b2b_sltu_done", 32'(bus.done), 32'd1);
        chk("b2b_sltu_res", bus.result, 32'd0);
        chk("b2b_sltu_zero", 32'(bus.zero), 32'd1);
        cyc();
        chk("b2b_idle_done", 32'(bus.done), 32'd0);

        muldiv(ALU_OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, lat, busyn);
        chk("mult_latency", 32'(lat), 32'd33);
        chk("mult_busy_cycles", 32'(busyn), 32'd32);
        chk("mult_res", bus.result, 32'hFFFF_FFEB);
        chk("mult_ovf", 32'(bus.overflow), 32'd0);
        cyc();
        chk("mult_done_pulse", 32'(bus.done), 32'd0);
        single("mult_mfhi", ALU_OP_MFHI, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single("mult_mflo", ALU_OP_MFLO, '0, '0, 32'hFFFF_FFEB, 1'b0, 1'b0);

        muldiv(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, lat, busyn);
        chk("div_latency", 32'(lat), 32'd33);
        chk("div_res", bus.result, 32'hFFFF_FFFD);
        chk("div_dz", 32'(bus.div_zero), 32'd0);
        single("div_mfhi", ALU_OP_MFHI, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        single("divu_zero", ALU_OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        single("divz_mfhi", ALU_OP_MFHI, '0, '0, 32'd7, 1'b0, 1'b0);
        single("divz_mflo", ALU_OP_MFLO, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // ADD poked while busy must vanish; MFHI issued in FIN sees the new HI
        muldiv(ALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, lat, busyn);
        chk("multu_latency", 32'(lat), 32'd33);
        chk("multu_res", bus.result, 32'h0000_0001);
        bus.start = 1'b0;
        cyc();
        chk("fin_mfhi_done", 32'(bus.done), 32'd1);
        chk("fin_mfhi_res", bus.result, 32'hFFFF_FFFE);
        cyc();
        chk("multu_no_extra_done", 32'(bus.done), 32'd0);
        single("multu_mflo", ALU_OP_MFLO, '0, '0, 32'h0000_0001, 1'b0, 1'b0);

        muldiv(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, busyn);
        chk("divmin_latency", 32'(lat), 32'd33);
        chk("divmin_res", bus.result, 32'h8000_0000);
        chk("divmin_dz", 32'(bus.div_zero), 32'd0);
        single("divmin_mfhi", ALU_OP_MFHI, '0, '0, 32'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a divide
        bus.start = 1'b1; bus.control = ALU_OP_DIV; bus.A = 32'd100; bus.B = 32'd3;
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        cyc();
        cyc();
        chk("abort_held_done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;
        cyc();
        chk("abort_after_done", 32'(bus.done), 32'd0);
        single("abort_mfhi", ALU_OP_MFHI, '0, '0, 32'd0, 1'b0, 1'b0);
        single("abort_mflo", ALU_OP_MFLO, '0, '0, 32'd0, 1'b0, 1'b0);
        single("post_add", ALU_OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
